bcd_stopwatch_ctrl: RTL and testbench
=====================================

# bcd_stopwatch_ctrl

Run/stop/clear controller sequencing a chain of decade (0–9) counters as a multi-digit BCD stopwatch. A prescaler derives a count tick from `clk`, an FSM gates the chain, and carries ripple digit to digit. Sits between push-button/command logic and the display driver, which consumes the packed BCD digit bus.

## Interface
- `DIGITS`, 4: number of BCD decades, legal range 1–8.
- `PRESCALE`, 1000: `clk` cycles per count tick, ≥2.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: level sampled each edge; request counting.
- `stop` input 1: request pause.
- `clear` input 1: request zeroing and return to idle.
- `lap` input 1: freeze displayed value. Present only with `BCD_SW_LAP_EN`.
- `digits` output 4*DIGITS: packed BCD. Digit 0 (least significant) is in `[3:0]`.
- `running` output 1: high while in RUN.
- `tick` output 1: one-cycle pulse on each counted increment.
- `overflow` output 1: sticky; high in FULL.

## Operation
- FSM states: IDLE, RUN, PAUSE, FULL. Encoding is free.
- IDLE:
  - `start` → RUN.
  - `clear` → stay in IDLE and zero the digits.
- RUN:
  - `stop` → PAUSE.
  - `clear` → IDLE.
  - A tick taken while all digits are 9 → FULL.
- PAUSE:
  - `start` → RUN.
  - `clear` → IDLE.
  - Digits and prescaler hold.
- FULL:
  - Only `clear` exits, to IDLE.
  - Digits hold at all-9s.
  - `overflow`=1.
- Command priority when several are high in one cycle: `clear` > `stop` > `start`.
- Prescaler:
  - Counts 0..PRESCALE-1, advancing only in RUN.
  - `tick` fires when the prescaler equals PRESCALE-1, then the prescaler wraps to 0.
  - `clear` zeroes the prescaler.
  - PAUSE preserves the prescaler, so partial intervals are not lost.
- Digit chain, on each tick:
  - Digit 0 increments.
  - A digit at 9 wraps to 0 and carries into the next digit in the same edge, like a combinational ripple.
  - Digit values 10–15 are unreachable. If one is forced, the next increment loads 0.
- `digits` is always valid BCD.

## Timing
- Reset values: `digits`=0, `running`=0, `tick`=0, `overflow`=0, state IDLE, prescaler 0, lap latch cleared.
- Latency from command to state:
  - A `start` sampled at edge N gives `running`=1 after edge N.
  - The first tick comes at edge N+PRESCALE.
- `tick` and the digit update are registered together on the same edge.
- `stop` at the edge where the prescaler reaches PRESCALE-1: the stop wins and no tick is issued.
- `clear` at a tick edge: the digits become 0 and no increment is applied.
- `rst_n` asserted mid-count:
  - All state clears immediately, independent of `clk`.
  - Deassertion is synchronised externally.
- Commands are levels. Holding `start` in RUN has no effect.

## Configuration
- Macro: `BCD_SW_LAP_EN`.
- Defined:
  - The `lap` port exists.
  - A rising edge of `lap` in RUN or PAUSE captures the live digits into a lap register, and `digits` shows the lap register.
  - Counting continues internally.
  - A second `lap` rising edge releases the freeze and `digits` returns to live values on the next edge.
  - `clear` also releases the freeze.
- Undefined:
  - No `lap` port and no lap register.
  - `digits` always shows the live counter.

## Structure
- Package `bcd_sw_pkg` holds:
  - the state enum `sw_state_t`;
  - the constant `BCD_MAX` = 4'd9;
  - the constant `BCD_W` = 4.
- Sub-module `bcd_digit`: one decade counter.
  - Inputs: `clk`, `rst_n`, `clr`, `en`.
  - Outputs: `q[3:0]`, `carry_out` (= `en` and `q`==9).
- `bcd_stopwatch_ctrl` instantiates DIGITS copies in a generate loop. The `en` of each digit is the `carry_out` of the previous digit; digit 0 is enabled by `tick`.
- The FSM, prescaler and lap logic stay in the top module.

## Test plan
All scenarios use DIGITS=2, PRESCALE=4.
- Reset, then `start` for one cycle → `running`=1 one edge later; `tick` every 4 cycles; after 12 ticks `digits`=8'h12.
- Run to 8'h09, then one more tick → `digits`=8'h10; digit 0 wraps and digit 1 increments on the same edge.
- `stop` after 2 prescaler cycles, hold 10 cycles, then `start` → first tick arrives 2 cycles after `running` rises; `digits` unchanged while paused.
- Run to 8'h99, then the next tick → state FULL, `digits`=8'h99, `overflow`=1, `running`=0; `start` ignored; `clear` → `digits`=0, `overflow`=0.
- `start`, `stop` and `clear` high together in RUN → IDLE, `digits`=0; `rst_n` low mid-prescale → all outputs 0 asynchronously.
- With `BCD_SW_LAP_EN` defined, `lap` pulse at 8'h05, wait 3 ticks → `digits` stays 8'h05; second `lap` pulse → `digits`=8'h08.

Source files
------------

// File: rtl/bcd_sw_pkg.sv
// Shared types and constants for the BCD stopwatch controller.
package bcd_sw_pkg;

  // Controller states; the encoding carries no meaning outside this block.
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    FULL
  } sw_state_t;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Next value of one decade. Codes 10..15 cannot occur in normal operation.
  // If one is forced, it goes to 0 so the display returns to valid BCD.
  function automatic logic [BCD_W-1:0] bcd_next(input logic [BCD_W-1:0] d);
    return (d >= BCD_MAX) ? '0 : d + 1'b1;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade (0-9) counter cell of the stopwatch chain.
// carry_out is combinational, so a carry reaches the next digit on the same edge.
module bcd_digit
  import bcd_sw_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [BCD_W-1:0] q,
  output logic             carry_out
);

  // Decade register: clr wins over en.
  // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= bcd_next(q);
    end
  end

  assign carry_out = en && (q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Run/stop/clear controller for a multi-digit BCD stopwatch.
// A prescaler makes the count tick, an FSM gates it, and a chain of
// bcd_digit cells ripples the carries.
// Optional feature: define BCD_SW_LAP_EN to add the lap input and the lap freeze register.
module bcd_stopwatch_ctrl
  import bcd_sw_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
`ifdef BCD_SW_LAP_EN
  input  logic                    lap,
`endif
  output logic [BCD_W*DIGITS-1:0] digits,
  output logic                    running,
  output logic                    tick,
  output logic                    overflow
);

  localparam int             PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);

  sw_state_t                 state;
  logic [PW-1:0]             presc;
  logic                      tick_fire;
  logic                      all_nines;
  logic                      chain_en;
  logic [DIGITS:0]           carry;
  logic [BCD_W*DIGITS-1:0]   live;

  // A tick is taken only in RUN at the last prescale count.
  // A stop or clear in the same cycle suppresses it.
  always_comb begin
    tick_fire = (state == RUN) && !clear && !stop && (presc == PRESC_LAST);
  end

  // Detect a saturated display so the final tick freezes at all-9s instead of wrapping.
  // NOTE: give every always_comb output a default first so no path can infer a latch.
  always_comb begin
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (live[i*BCD_W +: BCD_W] != BCD_MAX) all_nines = 1'b0;
    end
  end

  assign chain_en = tick_fire && !all_nines;
  assign carry[0] = chain_en;

  // Decade chain: each digit is enabled by the carry out of the digit below it.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clear),
      .en        (carry[g]),
      .q         (live[g*BCD_W +: BCD_W]),
      .carry_out (carry[g+1])
    );
  end

  // Controller FSM and prescaler. Command priority is clear > stop > start.
  // The tick output is registered on the same edge that updates the digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      presc    <= '0;
      running  <= 1'b0;
      tick     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      tick <= tick_fire;
      if (clear) begin
        state    <= IDLE;
        presc    <= '0;
        running  <= 1'b0;
        overflow <= 1'b0;
      end else begin
        case (state)
          IDLE, PAUSE: begin
            if (!stop && start) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (stop) begin
              // The prescaler holds, so a partial interval survives the pause.
              state   <= PAUSE;
              running <= 1'b0;
            end else if (tick_fire) begin
              presc <= '0;
              // A carry out of the top digit would also mean the range is exhausted.
              if (all_nines || carry[DIGITS]) begin
                state    <= FULL;
                running  <= 1'b0;
                overflow <= 1'b1;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          FULL: begin
            // Only clear leaves FULL.
          end
          default: begin
            state    <= IDLE;
            running  <= 1'b0;
            overflow <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef BCD_SW_LAP_EN
  logic                    lap_q;
  logic                    lap_active;
  logic [BCD_W*DIGITS-1:0] lap_reg;

  // Lap freeze: the first rising edge of lap captures the display, and the
  // next rising edge releases it. Counting continues underneath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_q      <= 1'b0;
      lap_active <= 1'b0;
      lap_reg    <= '0;
    end else begin
      lap_q <= lap;
      if (clear) begin
        lap_active <= 1'b0;
      end else if (lap && !lap_q) begin
        if (lap_active) begin
          lap_active <= 1'b0;
        end else if (state == RUN || state == PAUSE) begin
          lap_active <= 1'b1;
          lap_reg    <= live;
        end
      end
    end
  end

  assign digits = lap_active ? lap_reg : live;
`else
  assign digits = live;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Scoreboard bench for bcd_stopwatch_ctrl with DIGITS=2 and PRESCALE=4.
// Before each tick, the stimulus pushes the value the display should show.
// The monitor pops that value on every tick pulse and compares it.
module tb_bcd_stopwatch_ctrl;

  localparam int DIGITS   = 2;
  localparam int PRESCALE = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic       clear = 1'b0;
`ifdef BCD_SW_LAP_EN
  logic       lap   = 1'b0;
`endif
  logic [7:0] digits;
  logic       running;
  logic       tick;
  logic       overflow;

  int         checks = 0;
  int         errors = 0;
  int         model  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  bcd_stopwatch_ctrl #(
    .DIGITS   (DIGITS),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
`ifdef BCD_SW_LAP_EN
    .lap      (lap),
`endif
    .digits   (digits),
    .running  (running),
    .tick     (tick),
    .overflow (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Count one more tick in the model and queue the value it should display.
  task automatic advance();
    model++;
    exp_q.push_back(to_bcd(model));
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Apply commands for one sampling edge, then return at the following negedge.
  task automatic cmd(input logic s, input logic p, input logic c);
    start = s;
    stop  = p;
    clear = c;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
  endtask

  // Wait, with a bound, for the next tick pulse and check how many cycles it took.
  task automatic wait_tick(input int exp_cyc, input string name);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!tick && cyc < 40);
    check(name, cyc, exp_cyc);
  endtask

`ifdef BCD_SW_LAP_EN
  task automatic pulse_lap();
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
  endtask
`endif

  // Monitor: every tick pulse must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tick) begin
        check("tick_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("tick_digits", digits, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_digits", digits, 8'h00);
    check("reset_running", running, 1'b0);
    check("reset_tick", tick, 1'b0);
    check("reset_overflow", overflow, 1'b0);

    // Start, then 12 ticks. Tick 10 carries 09 into 10.
    cmd(1'b1, 1'b0, 1'b0);
    check("running_after_start", running, 1'b1);
    advance();
    wait_tick(4, "first_tick_latency");
    for (int i = 2; i <= 12; i++) begin
      advance();
      wait_tick(4, "tick_period");
    end
    check("digits_after_12", digits, 8'h12);

    // Pause with the prescaler at 2. After resuming, the first tick comes 2 cycles later.
    step(2);
    cmd(1'b0, 1'b1, 1'b0);
    check("running_paused", running, 1'b0);
    step(10);
    check("digits_hold_paused", digits, 8'h12);
    cmd(1'b1, 1'b0, 1'b0);
    check("running_resumed", running, 1'b1);
    advance();
    wait_tick(2, "resume_tick_latency");

    // Count to 99. The next tick enters FULL and the display stays at 99.
    while (model < 99) begin
      advance();
      wait_tick(4, "tick_period");
    end
    exp_q.push_back(8'h99);
    wait_tick(4, "overflow_tick");
    check("full_overflow", overflow, 1'b1);
    check("full_running", running, 1'b0);
    check("full_digits", digits, 8'h99);
    cmd(1'b1, 1'b0, 1'b0);
    step(8);
    check("full_ignores_start", running, 1'b0);
    check("full_digits_hold", digits, 8'h99);
    cmd(1'b0, 1'b0, 1'b1);
    check("clear_digits", digits, 8'h00);
    check("clear_overflow", overflow, 1'b0);
    model = 0;

    // With start, stop and clear all high in RUN, clear wins.
    cmd(1'b1, 1'b0, 1'b0);
    advance();
    wait_tick(4, "tick_after_clear");
    step(1);
    cmd(1'b1, 1'b1, 1'b1);
    check("priority_running", running, 1'b0);
    check("priority_digits", digits, 8'h00);
    model = 0;
    step(6);
    check("idle_digits_stay", digits, 8'h00);

    // Asynchronous reset in the middle of a prescale interval.
    cmd(1'b1, 1'b0, 1'b0);
    advance();
    wait_tick(4, "tick_before_reset");
    step(1);
    check("running_before_reset", running, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_digits", digits, 8'h00);
    check("async_rst_running", running, 1'b0);
    check("async_rst_tick", tick, 1'b0);
    check("async_rst_overflow", overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model = 0;

`ifdef BCD_SW_LAP_EN
    // Lap at 05 freezes the display while counting continues to 08.
    cmd(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      advance();
      wait_tick(4, "lap_pre_tick");
    end
    step(1);
    pulse_lap();
    check("lap_capture", digits, 8'h05);
    for (int i = 0; i < 3; i++) begin
      model++;
      exp_q.push_back(8'h05);
      wait_tick((i == 0) ? 2 : 4, "lap_frozen_tick");
    end
    check("lap_hold", digits, 8'h05);
    step(1);
    pulse_lap();
    check("lap_release", digits, to_bcd(model));
`endif

    step(2);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
